pipe_barrel_shifter: RTL and testbench



---
 rtl/pipe_barrel_shifter_if.sv | 27 ++
 rtl/pipe_barrel_shifter.sv | 102 ++++++++++
 tb/tb_pipe_barrel_shifter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_barrel_shifter_if.sv
// Valid/ready stream bundle for pipe_barrel_shifter.
// Operand beat in (data, amt, mode), shifted result beat out.
interface pipe_barrel_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Fully pipelined barrel shifter, one shift level per stage.
// Define BSH_ROTATE_EN to build rotate-left for mode 11.
module pipe_barrel_shifter #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  pipe_barrel_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
`ifdef BSH_ROTATE_EN
  localparam logic [1:0] MODE_ROL = 2'b11;
`endif
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] d_q [SHW];
  logic [WIDTH-1:0] d_n [SHW];
  logic [SHW-1:0]   a_q [SHW];
  logic [SHW-1:0]   a_n [SHW];
  logic [1:0]       m_q [SHW];
  logic [1:0]       m_n [SHW];
  logic             s_q [SHW];
  logic             s_n [SHW];
  logic [SHW-1:0]   v_q;
  logic [SHW-1:0]   v_n;
  logic             z_q;
  logic             stall;
  logic             en;

  function automatic logic [WIDTH-1:0] lvl(
    input logic [WIDTH-1:0] d,
    input logic             go,
    input int               sh,
    input logic [1:0]       m,
    input logic             s
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (go) begin
      unique case (1'b1)
        (m == MODE_SRL): r = d >> sh;
        (m == MODE_SRA): r = (d >> sh) | ({WIDTH{s}} & ~(ONES >> sh));
`ifdef BSH_ROTATE_EN
        (m == MODE_ROL): r = (d << sh) | (d >> (WIDTH - sh));
`endif
        default:         r = d << sh;
      endcase
    end
    return r;
  endfunction

  // One global stall freezes every stage, so bubbles never collapse.
  assign stall        = v_q[SHW-1] && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = en;

  always_comb begin
    d_n[0] = lvl(bus.in_data, bus.in_amt[0], 1,
                 bus.in_mode, bus.in_data[WIDTH-1]);
    a_n[0] = bus.in_amt;
    m_n[0] = bus.in_mode;
    s_n[0] = bus.in_data[WIDTH-1];
    v_n[0] = bus.in_valid && bus.in_ready;
    for (int k = 1; k < SHW; k++) begin
      d_n[k] = lvl(d_q[k-1], a_q[k-1][k], 1 << k,
                   m_q[k-1], s_q[k-1]);
      a_n[k] = a_q[k-1];
      m_n[k] = m_q[k-1];
      s_n[k] = s_q[k-1];
      v_n[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        d_q[k] <= '0;
        a_q[k] <= '0;
        m_q[k] <= '0;
        s_q[k] <= 1'b0;
      end
      v_q <= '0;
      z_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < SHW; k++) begin
        d_q[k] <= d_n[k];
        a_q[k] <= a_n[k];
        m_q[k] <= m_n[k];
        s_q[k] <= s_n[k];
      end
      v_q <= v_n;
      z_q <= (d_n[SHW-1] == '0);
    end
  end

  assign bus.out_valid = v_q[SHW-1];
  assign bus.out_data  = d_q[SHW-1];
  assign bus.out_zero  = z_q;
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Bench for pipe_barrel_shifter at WIDTH = 32.
// Scoreboard model plus hand-computed literals.
module tb_pipe_barrel_shifter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_barrel_shifter_if #(.WIDTH(W)) bus ();

  pipe_barrel_shifter #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d,
                                        input int a,
                                        input logic [1:0] m);
`ifdef BSH_ROTATE_EN
    logic [63:0] w;
`endif
    case (m)
      2'b01: return d >> a;
      2'b10: return 32'($signed(d) >>> a);
      2'b11: begin
`ifdef BSH_ROTATE_EN
        w = {d, d} << a;
        return w[63:32];
`else
        return d << a;
`endif
      end
      default: return d << a;
    endcase
  endfunction

  typedef struct {
    logic [31:0] exp;
    logic [31:0] lit;
    bit          hl;
    int          cyc;
    int          st;
  } item_t;

  item_t       q[$];
  int          cyc = 0;
  int          stalls = 0;
  bit          seen = 0;
  bit          hold = 0;
  logic [31:0] held;
  logic [31:0] cur_lit = '0;
  bit          cur_hl = 0;

  always @(posedge clk) cyc++;

  // Sampled mid-cycle; inputs only move just after posedge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      seen = 0;
      hold = 0;
    end else begin
      if (hold)
        chk("hold_data", bus.out_data, held);
      hold = 0;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", bus.out_valid, 1'b0);
        end else begin
          if (!seen) begin
            chk("latency", cyc, q[0].cyc + 5 + stalls - q[0].st);
            seen = 1;
          end
          if (bus.out_ready) begin
            chk("data", bus.out_data, q[0].exp);
            chk("zero", bus.out_zero, q[0].exp == 32'h0);
            if (q[0].hl)
              chk("literal", bus.out_data, q[0].lit);
            void'(q.pop_front());
            seen = 0;
          end else begin
            chk("stall_in_ready", bus.in_ready, 1'b0);
            stalls++;
            hold = 1;
            held = bus.out_data;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back('{model(bus.in_data, int'(bus.in_amt), bus.in_mode),
                      cur_lit, cur_hl, cyc, stalls});
    end
  end

  task automatic send(input logic [31:0] d, input int a,
                      input logic [1:0] m, input logic [31:0] lit,
                      input bit hl);
    bit acc;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = 5'(a);
    bus.in_mode  = m;
    cur_lit      = lit;
    cur_hl       = hl;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", acc, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_zero", bus.out_zero, 1'b0);

    chk("model_srl", model(32'h80000000, 31, 2'b01), 32'h00000001);
    chk("model_sra", model(32'h80000000, 4, 2'b10), 32'hF8000000);
    chk("model_sll", model(32'h00000003, 31, 2'b00), 32'h80000000);
`ifdef BSH_ROTATE_EN
    chk("model_rol", model(32'h12345678, 8, 2'b11), 32'h34567812);
`else
    chk("model_rol", model(32'h80000001, 1, 2'b11), 32'h00000002);
`endif

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("release_in_ready", bus.in_ready, 1'b1);

    for (int i = 1; i <= 8; i++) begin
      send(32'(i), 1, 2'b00, 32'(i * 2), 1);
      send(32'(i), 31, 2'b00, (i % 2) ? 32'h80000000 : 32'h0, 1);
    end
    drain();

    send(32'h80000000, 31, 2'b01, 32'h00000001, 1);
    send(32'h80000000, 4, 2'b10, 32'hF8000000, 1);
    send(32'h7FFFFFFF, 4, 2'b10, 32'h07FFFFFF, 1);
    send(32'hFFFFFFFF, 0, 2'b00, 32'hFFFFFFFF, 1);
`ifdef BSH_ROTATE_EN
    send(32'h80000001, 1, 2'b11, 32'h00000003, 1);
    send(32'h12345678, 8, 2'b11, 32'h34567812, 1);
`else
    send(32'h80000001, 1, 2'b11, 32'h00000002, 1);
    send(32'h12345678, 8, 2'b11, 32'h34567800, 1);
`endif
    send(32'h00000001, 31, 2'b00, 32'h80000000, 1);
    send(32'h00000002, 31, 2'b00, 32'h00000000, 1);
    send(32'hC3A50F01, 13, 2'b10, 32'hFFFE1D28, 1);
    drain();

    fork
      for (int i = 0; i < 10; i++)
        send(32'h9E3779B9 * 32'(i + 1), (i * 7) % 32, 2'(i), '0, 0);
      begin
        repeat (7) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    bus.out_ready = 1'b0;
    send(32'h0000F00D, 4, 2'b00, 32'h000F00D0, 1);
    send(32'hDEADBEEF, 8, 2'b01, 32'h00DEADBE, 1);
    send(32'h80000000, 1, 2'b10, 32'hC0000000, 1);
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("prefill_valid", bus.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_data", bus.out_data, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("rerelease_in_ready", bus.in_ready, 1'b1);
    send(32'h00000005, 2, 2'b00, 32'h00000014, 1);
    drain();
    repeat (8) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
